// File: rtl/psad_best_match.sv
// Reduces partial-SAD batches to block SADs and tracks the minimum (and its
// candidate index) over a search window. Optional zero-MV bias: PSAD_ZERO_MV_BIAS_EN.
//
// state  | meaning
// IDLE   | waiting for block_start, batches ignored
// SEARCH | accepting batches until NUM_BATCHES are taken
// DRAIN  | letting the sum/compare pipeline empty
// DONE   | result presented until result_ready
module psad_best_match #(
  parameter int PIXELS_IN_BATCH = 16,
  parameter int EDGE_LEN        = 8,
  parameter int PSAD_BIT_WIDTH  = 11,
  parameter int NUM_BATCHES     = 16,
  parameter int SAD_BIT_WIDTH   = PSAD_BIT_WIDTH + $clog2(EDGE_LEN),
  parameter int INDEX_BIT_WIDTH = $clog2(NUM_BATCHES * PIXELS_IN_BATCH),
  parameter int ZERO_MV_INDEX   = 136,
  parameter int ZERO_MV_BIAS    = 64
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               block_start,
  input  logic [PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH-1:0] psad_addend_batch,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  output logic                                               result_valid,
  input  logic                                               result_ready,
  output logic [SAD_BIT_WIDTH-1:0]                           best_sad,
  output logic [INDEX_BIT_WIDTH-1:0]                         best_index
);

  localparam int CNT_W = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic                       s1_valid_q, s2_valid_q;
  logic [CNT_W-1:0]           s1_batch_q;
  logic [SAD_BIT_WIDTH-1:0]   s1_sad_q [PIXELS_IN_BATCH];
  logic [SAD_BIT_WIDTH-1:0]   s1_sum_d [PIXELS_IN_BATCH];
  logic [SAD_BIT_WIDTH-1:0]   min_sad_q;
  logic [INDEX_BIT_WIDTH-1:0] min_idx_q;
  logic [SAD_BIT_WIDTH-1:0]   best_sad_q;
  logic [INDEX_BIT_WIDTH-1:0] best_idx_q;

  logic [SAD_BIT_WIDTH-1:0]   cand_sad [PIXELS_IN_BATCH];
  logic [INDEX_BIT_WIDTH-1:0] cand_idx [PIXELS_IN_BATCH];
  logic [SAD_BIT_WIDTH-1:0]   bat_min;
  logic [INDEX_BIT_WIDTH-1:0] bat_idx;

  logic accept, last_accept;

  // block_start wins over a coincident in_valid
  assign accept      = (state_q == S_SEARCH) && in_valid && !block_start;
  assign last_accept = accept && (cnt_q == CNT_W'(NUM_BATCHES - 1));

  assign in_ready     = (state_q == S_SEARCH);
  assign result_valid = (state_q == S_DONE);
  assign best_sad     = best_sad_q;
  assign best_index   = best_idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_SEARCH: if (last_accept) state_d = S_DRAIN;
      S_DRAIN:  if (!s1_valid_q && !s2_valid_q) state_d = S_DONE;
      S_DONE:   if (result_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (block_start) state_d = S_SEARCH;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    for (int p = 0; p < PIXELS_IN_BATCH; p++) begin
      s1_sum_d[p] = '0;
      for (int c = 0; c < EDGE_LEN; c++) begin
        s1_sum_d[p] = s1_sum_d[p] + SAD_BIT_WIDTH'(
          psad_addend_batch[(c*PIXELS_IN_BATCH + p)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
      end
    end
  end

  // Lowest p wins ties inside the batch (strict less-than, ascending scan)
  always_comb begin
    for (int p = 0; p < PIXELS_IN_BATCH; p++) begin
      cand_idx[p] = INDEX_BIT_WIDTH'(s1_batch_q) * INDEX_BIT_WIDTH'(PIXELS_IN_BATCH)
                  + INDEX_BIT_WIDTH'(p);
      cand_sad[p] = s1_sad_q[p];
`ifdef PSAD_ZERO_MV_BIAS_EN
      if (cand_idx[p] == INDEX_BIT_WIDTH'(ZERO_MV_INDEX)) begin
        cand_sad[p] = (s1_sad_q[p] > SAD_BIT_WIDTH'(ZERO_MV_BIAS))
                    ? s1_sad_q[p] - SAD_BIT_WIDTH'(ZERO_MV_BIAS) : '0;
      end
`endif
    end
    bat_min = cand_sad[0];
    bat_idx = cand_idx[0];
    for (int p = 1; p < PIXELS_IN_BATCH; p++) begin
      if (cand_sad[p] < bat_min) begin
        bat_min = cand_sad[p];
        bat_idx = cand_idx[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_batch_q <= '0;
      for (int p = 0; p < PIXELS_IN_BATCH; p++) s1_sad_q[p] <= '0;
      min_sad_q  <= '1;
      min_idx_q  <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      if (block_start) begin
        cnt_q      <= '0;
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
        min_sad_q  <= '1;
        min_idx_q  <= '0;
      end else begin
        s1_valid_q <= accept;
        s2_valid_q <= s1_valid_q;
        if (accept) begin
          cnt_q      <= cnt_q + CNT_W'(1);
          s1_batch_q <= cnt_q;
          for (int p = 0; p < PIXELS_IN_BATCH; p++) s1_sad_q[p] <= s1_sum_d[p];
        end
        if (s1_valid_q && (bat_min < min_sad_q)) begin
          min_sad_q <= bat_min;
          min_idx_q <= bat_idx;
        end
      end
      if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
        best_sad_q <= min_sad_q;
        best_idx_q <= min_idx_q;
      end
    end
  end

endmodule

// File: tb/tb_psad_best_match.sv
// Directed bench for psad_best_match: hand-computed SAD/index results, latency,
// handshake, restart and reset behaviour at default parameters.
module tb_psad_best_match;

  localparam int P  = 16;
  localparam int E  = 8;
  localparam int PW = 11;
  localparam int BW = PW * E * P;

  typedef logic [BW-1:0] batch_t;

  logic         clk;
  logic         rst;
  logic         block_start;
  batch_t       psad;
  logic         in_valid;
  logic         in_ready;
  logic         result_valid;
  logic         result_ready;
  logic [13:0]  best_sad;
  logic [7:0]   best_index;

  int n_pass  = 0;
  int n_total = 0;

  psad_best_match dut (
    .clk               (clk),
    .rst               (rst),
    .block_start       (block_start),
    .psad_addend_batch (psad),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .result_valid      (result_valid),
    .result_ready      (result_ready),
    .best_sad          (best_sad),
    .best_index        (best_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic batch_t fill(int v);
    batch_t b;
    b = '0;
    for (int i = 0; i < E * P; i++) b[i*PW +: PW] = PW'(v);
    return b;
  endfunction

  function automatic batch_t set_col(batch_t b, int c, int p, int v);
    batch_t r;
    r = b;
    r[(c*P + p)*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic batch_t set_cand(batch_t b, int p, int v);
    batch_t r;
    r = b;
    for (int c = 0; c < E; c++) r[(c*P + p)*PW +: PW] = PW'(v);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      step();
      n++;
    end
    chk("result_timeout", int'(result_valid), 1);
  endtask

  task automatic start();
    block_start = 1'b1;
    step();
    block_start = 1'b0;
  endtask

  task automatic consume();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; block_start = 1'b0; in_valid = 1'b0; result_ready = 1'b0; psad = '0;
    step(); step();
    chk("rst_in_ready",     int'(in_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_best_sad",     int'(best_sad), 0);
    chk("rst_best_index",   int'(best_index), 0);

    rst = 1'b1;
    psad = fill(1); in_valid = 1'b1;
    step();
    chk("idle_ignores_valid", int'(in_ready), 0);
    in_valid = 1'b0;
    result_ready = 1'b1;
    step();
    chk("idle_ready_no_effect", int'(result_valid), 0);
    result_ready = 1'b0;

    // all partials 1: every SAD 8, tie keeps index 0; exact latency
    start();
    chk("search_in_ready", int'(in_ready), 1);
    psad = fill(1); in_valid = 1'b1;
    repeat (16) step();
    in_valid = 1'b0;
    chk("drain_in_ready", int'(in_ready), 0);
    step(); chk("lat_cycle1", int'(result_valid), 0);
    step(); chk("lat_cycle2", int'(result_valid), 0);
    step(); chk("lat_cycle3", int'(result_valid), 1);
    chk("ones_sad",   int'(best_sad), 8);
    chk("ones_index", int'(best_index), 0);
    consume();
    chk("ones_consumed", int'(result_valid), 0);

    // batch 5 candidate 3 zero, others SAD 16; valid gap after batch 8
    start();
    for (int b = 0; b < 16; b++) begin
      psad = fill(2);
      if (b == 5) psad = set_cand(psad, 3, 0);
      in_valid = 1'b1;
      step();
      if (b == 8) begin
        in_valid = 1'b0;
        repeat (3) step();
      end
    end
    in_valid = 1'b0;
    wait_result();
    chk("zero_sad",   int'(best_sad), 0);
    chk("zero_index", int'(best_index), 83);
    consume();

    // indices 10 and 200 both SAD 5, others 40; hold with result_ready low
    start();
    for (int b = 0; b < 16; b++) begin
      psad = fill(5);
      if (b == 0)  psad = set_col(set_cand(psad, 10, 0), 0, 10, 5);
      if (b == 12) psad = set_col(set_cand(psad, 8, 0), 0, 8, 5);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_result();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", int'(result_valid), 1);
    end
    chk("tie_sad",   int'(best_sad), 5);
    chk("tie_index", int'(best_index), 10);
    consume();
    chk("tie_consumed", int'(result_valid), 0);

    // restart after 8 batches; restart cycle also carries an all-zero batch
    start();
    for (int b = 0; b < 8; b++) begin
      psad = fill(2);
      if (b == 0) psad = set_cand(psad, 2, 0);
      in_valid = 1'b1;
      step();
    end
    psad = fill(0); in_valid = 1'b1; block_start = 1'b1;
    step();
    block_start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      psad = fill(3);
      if (b == 1) psad = set_cand(psad, 14, 1);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_result();
    chk("restart_sad",   int'(best_sad), 8);
    chk("restart_index", int'(best_index), 30);
    consume();

    // reset while batch 9 is offered
    start();
    psad = fill(4); in_valid = 1'b1;
    repeat (8) step();
    rst = 1'b0;
    step();
    chk("midrst_in_ready",     int'(in_ready), 0);
    chk("midrst_result_valid", int'(result_valid), 0);
    chk("midrst_best_sad",     int'(best_sad), 0);
    chk("midrst_best_index",   int'(best_index), 0);
    rst = 1'b1;
    step();
    chk("midrst_stays_idle", int'(in_ready), 0);
    in_valid = 1'b0;

    // maximum partials: SAD 16376 without overflow
    start();
    psad = fill(2047); in_valid = 1'b1;
    repeat (16) step();
    in_valid = 1'b0;
    wait_result();
    chk("max_sad",   int'(best_sad), 16376);
    chk("max_index", int'(best_index), 0);
    block_start = 1'b1;
    step();
    block_start = 1'b0;
    chk("done_restart_drops", int'(result_valid), 0);
    chk("done_restart_ready", int'(in_ready), 1);

    // zero-MV candidate 136 SAD 100 vs index 0 SAD 50, others 800
    for (int b = 0; b < 16; b++) begin
      psad = fill(100);
      if (b == 0) psad = set_col(set_cand(psad, 0, 0), 0, 0, 50);
      if (b == 8) psad = set_col(set_cand(psad, 8, 0), 0, 8, 100);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    wait_result();
`ifdef PSAD_ZERO_MV_BIAS_EN
    chk("bias_sad",   int'(best_sad), 36);
    chk("bias_index", int'(best_index), 136);
`else
    chk("bias_sad",   int'(best_sad), 50);
    chk("bias_index", int'(best_index), 0);
`endif
    consume();
    chk("bias_consumed", int'(result_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psad_best_match.md
Name: psad_best_match

Overview:
- Downstream consumer of the absolute-difference systolic array's partial-SAD batch output.
- Each accepted batch carries EDGE_LEN column partial SADs for each of PIXELS_IN_BATCH candidate positions.
- An adder tree reduces each candidate's column partials to a full block SAD; a running comparator tracks the minimum across NUM_BATCHES batches.
- Reports the best SAD and its candidate index to the motion-vector stage through a valid/ready handshake.

Parameters:
PIXELS_IN_BATCH, 16, candidate positions per input batch
EDGE_LEN, 8, block edge length; column partials per candidate
PSAD_BIT_WIDTH, 11, width of one partial SAD
NUM_BATCHES, 16, batches per search window (256 candidates at defaults)
SAD_BIT_WIDTH, PSAD_BIT_WIDTH+$clog2(EDGE_LEN), full SAD width (14)
INDEX_BIT_WIDTH, $clog2(NUM_BATCHES*PIXELS_IN_BATCH), candidate index width (8)
ZERO_MV_INDEX, 136, candidate index of zero motion (used only with optional feature)
ZERO_MV_BIAS, 64, SAD reduction applied to ZERO_MV_INDEX (used only with optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-low
block_start  in  1  single-cycle pulse; begins a new search window
psad_addend_batch  in  PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH  partial SADs; field (c*PIXELS_IN_BATCH+p) holds column c, candidate p
in_valid  in  1  psad_addend_batch valid
in_ready  out  1  block accepts a batch this cycle
result_valid  out  1  best_sad/best_index valid
result_ready  in  1  downstream consumes result
best_sad  out  SAD_BIT_WIDTH  minimum SAD of window
best_index  out  INDEX_BIT_WIDTH  batch_count*PIXELS_IN_BATCH+p of the minimum

Behaviour:
- Reset (rst low at clk edge):
  - State goes to IDLE.
  - in_ready=0, result_valid=0, best_sad=0, best_index=0.
  - Internal running minimum is set to all-ones; batch counter and pipeline valids are cleared.
  - Reset mid-search discards everything.
- States:
  - IDLE: in_ready=0; in_valid ignored; block_start -> SEARCH.
  - SEARCH: in_ready=1. A batch is accepted when in_valid&&in_ready; the batch counter increments on each accept. When the accept is number NUM_BATCHES -> DRAIN.
  - DRAIN: in_ready=0. Waits until the pipeline is empty, then -> DONE.
  - DONE: result_valid=1; outputs are stable. result_ready -> IDLE, with result_valid low on the next cycle.
- Pipeline:
  - Stage 1, registered cycle after accept: per-candidate sum of EDGE_LEN partials, zero-extended to SAD_BIT_WIDTH. The sum never overflows.
  - Stage 2: comparator updates the running minimum and its index.
  - result_valid rises exactly 3 cycles after the final accept: 2 pipeline stages plus the DONE registration.
- Comparison:
  - Strict less-than, so ties keep the earlier (lower) index.
  - Within a batch, the reduction picks the lowest p on ties before comparing against the running minimum.
- block_start:
  - In any state: restarts the window. Counter cleared, minimum set to all-ones, pipeline valids flushed, state -> SEARCH next cycle.
  - In DONE: the unconsumed result is dropped (result_valid low next cycle).
  - block_start and in_valid in the same cycle: the batch is not accepted (in_ready is 0 in IDLE/DONE, and in SEARCH the restart takes priority).
- result_ready while result_valid=0 has no effect.
- in_valid gaps in SEARCH are allowed; the counter holds.

Optional Feature:
- Macro PSAD_ZERO_MV_BIAS_EN defined:
  - Stage-1 SAD of the candidate whose global index equals ZERO_MV_INDEX is reduced by ZERO_MV_BIAS, saturating at 0, before comparison.
  - best_sad reports the biased value.
- Macro undefined: no bias logic is synthesized; ZERO_MV_INDEX and ZERO_MV_BIAS are unused.

Test Plan:
- Reset then block_start; 16 batches with all partials=1 -> every SAD=8; result_valid 3 cycles after last accept; best_sad=8, best_index=0 (tie rule).
- Batch 5, candidate 3, all partials 0; all others 2 -> best_sad=0, best_index=83.
- Candidates 10 and 200 both SAD=5, others 40 -> best_index=10; result held with result_ready=0 for 10 cycles, then cleared one cycle after result_ready=1.
- block_start pulsed after batch 7, then 16 new batches with minimum at index 30 -> best_index=30 (pre-restart data ignored); also rst low during batch 9 -> in_ready=0, result_valid=0, best_sad=0.
- All partials=2047 -> SAD=16376 with no overflow; best_sad=16376.
- With PSAD_ZERO_MV_BIAS_EN: index 136 SAD=100, index 0 SAD=50 -> best_index=136, best_sad=36. Without the macro -> best_index=0, best_sad=50.
